// File: rtl/phy_scrambler_pkg.sv
// phy_scrambler_pkg: shared 802.11a scrambler constants, FSM states and LFSR step (S(x) = x^7 + x^4 + 1)
package phy_scrambler_pkg;
  localparam int SEED_LEN = 7;
  localparam int SERVICE_LEN_DEFAULT = 16;
  localparam int TAP_A = 6;
  localparam int TAP_B = 3;
  typedef enum logic [1:0] {IDLE, SEED, RUN, FLUSH} desc_state_t;
  function automatic logic [SEED_LEN:0] lfsr_step(input logic [SEED_LEN-1:0] s);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B];
    return {s[SEED_LEN-2:0], fb, fb};
  endfunction
endpackage

// File: rtl/scrambler_lfsr_core.sv
// scrambler_lfsr_core: 7-bit LFSR with serial-load (seed) and free-run modes
module scrambler_lfsr_core
  import phy_scrambler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                load,
  input  logic                x,
  output logic [SEED_LEN-1:0] state,
  output logic                fb
);
  logic [SEED_LEN:0] step;
  always_comb step = lfsr_step(state);
  assign fb = step[0];
  always_ff @(posedge clk)
    if (!reset || clr) state <= '0;
    else if (en) state <= load ? {state[SEED_LEN-2:0], x} : step[SEED_LEN:1];
endmodule

// File: rtl/service_descrambler.sv
// service_descrambler: recovers the scrambler seed from SERVICE bits and descrambles the frame; `SERVICE_STRIP_EN drops SERVICE outputs
module service_descrambler
  import phy_scrambler_pkg::*;
#(
  parameter int SERVICE_LEN = SERVICE_LEN_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                run,
  input  logic                x,
  input  logic                last,
  output logic                rdy,
  output logic                x_descrambled,
  output logic                valid,
  output logic                last_out,
  output logic [SEED_LEN-1:0] seed_state,
  output logic                seed_valid
);
  localparam int CW = $clog2(SERVICE_LEN + 1);
  desc_state_t st;
  logic [CW-1:0] cnt;
  logic [SEED_LEN-1:0] lfsr;
  logic fb, acc, dbit, seed_done, ov, ox;
  assign rdy = (st == SEED) || (st == RUN);
  assign acc = run & rdy;
  assign dbit = (st == RUN) & (x ^ fb);
  assign seed_done = (st == SEED) && (cnt == CW'(SEED_LEN - 1));
`ifdef SERVICE_STRIP_EN
  logic in_svc;
  assign in_svc = cnt < CW'(SERVICE_LEN);
  assign ov = acc & (!in_svc | last);
  assign ox = acc & !in_svc & dbit;
`else
  assign ov = acc;
  assign ox = acc & dbit;
`endif
  scrambler_lfsr_core u_lfsr (
    .clk(clk), .reset(reset), .clr(start), .en(acc), .load(st == SEED),
    .x(x), .state(lfsr), .fb(fb)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
      x_descrambled <= 1'b0;
      valid <= 1'b0;
      last_out <= 1'b0;
      seed_state <= '0;
      seed_valid <= 1'b0;
    end else begin
      valid <= ov;
      x_descrambled <= ox;
      last_out <= acc & last;
      if (start) begin
        st <= SEED;
        cnt <= '0;
        seed_valid <= 1'b0;
      end else if (st == FLUSH) st <= IDLE;
      else if (acc) begin
        cnt <= (cnt == CW'(SERVICE_LEN)) ? cnt : cnt + 1'b1;
        st <= last ? FLUSH : seed_done ? RUN : st;
        if (seed_done) begin
          seed_valid <= 1'b1;
          seed_state <= {lfsr[SEED_LEN-2:0], x};
        end
      end
    end
endmodule

// File: tb/tb_service_descrambler.sv
// tb_service_descrambler: directed self-checking bench for service_descrambler
module tb_service_descrambler;
`ifdef SERVICE_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, run = 1'b0, x = 1'b0, last = 1'b0;
  logic rdy, x_descrambled, valid, last_out, seed_valid;
  logic [6:0] seed_state;
  int n_tot = 0, n_pass = 0, n_fail = 0;
  always #5 clk = ~clk;
  service_descrambler dut (
    .clk(clk), .reset(reset), .start(start), .run(run), .x(x), .last(last),
    .rdy(rdy), .x_descrambled(x_descrambled), .valid(valid), .last_out(last_out),
    .seed_state(seed_state), .seed_valid(seed_valid)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input logic [6:0] seed, input int n, input int gap, input bit with_last, input string tag);
    logic [6:0] s;
    logic b, fb, l;
    int nv, ev;
    s = seed;
    nv = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_rdy_start"}, rdy, 1);
    for (int i = 0; i < n; i++) begin
      b = (i < 16) ? 1'b0 : 1'($urandom_range(0, 1));
      fb = s[6] ^ s[3];
      s = {s[5:0], fb};
      l = with_last && (i == n - 1);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk({tag, "_gap_valid"}, valid, 0);
      end
      run = 1'b1;
      x = b ^ fb;
      last = l;
      tick();
      run = 1'b0;
      last = 1'b0;
      nv += int'(valid);
      ev = STRIP ? int'(i >= 16 || l) : 1;
      chk({tag, "_valid"}, valid, ev);
      if (ev != 0) chk({tag, "_data"}, x_descrambled, (STRIP && i < 16) ? 1'b0 : b);
      chk({tag, "_last_out"}, last_out, l);
      if (i == 6) begin
        chk({tag, "_seed_valid"}, seed_valid, 1);
        chk({tag, "_seed_state"}, seed_state, s);
      end else if (i < 6) chk({tag, "_seed_early"}, seed_valid, 0);
    end
    if (with_last) begin
      chk({tag, "_vcount"}, nv, STRIP ? ((n > 16) ? n - 16 : 1) : n);
      chk({tag, "_rdy_flush"}, rdy, 0);
      tick();
      chk({tag, "_rdy_idle"}, rdy, 0);
      chk({tag, "_valid_idle"}, valid, 0);
      if (n < 7) chk({tag, "_seed_short"}, seed_valid, 0);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_rdy", rdy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_x", x_descrambled, 0);
    chk("rst_last", last_out, 0);
    chk("rst_seed_state", seed_state, 0);
    chk("rst_seed_valid", seed_valid, 0);
    reset = 1'b1;
    run = 1'b1;
    x = 1'b1;
    tick();
    run = 1'b0;
    chk("idle_run_ignored", valid, 0);
    run_frame(7'h7F, 40, 0, 1'b1, "ones");
    chk("ones_seed_hand", seed_state, 7'b0000111);
    chk("ones_seed_hold", seed_valid, 1);
    run_frame(7'b1000011, 1000, 0, 1'b1, "loop_a");
    run_frame(7'b1011101, 1000, 0, 1'b1, "loop_b");
    run_frame(7'h7F, 40, 2, 1'b1, "gapped");
    run_frame(7'b1011101, 4, 0, 1'b1, "short");
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("short_run_ignored", valid, 0);
      chk("short_rdy_low", rdy, 0);
    end
    run = 1'b0;
    run_frame(7'b0110010, 20, 0, 1'b0, "partial");
    run_frame(7'b1000011, 30, 0, 1'b1, "restart");
    run_frame(7'b0101010, 20, 0, 1'b0, "pre_reset");
    reset = 1'b0;
    run = 1'b1;
    tick();
    chk("mid_rst_rdy", rdy, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_seed_valid", seed_valid, 0);
    chk("mid_rst_seed_state", seed_state, 0);
    reset = 1'b1;
    tick();
    run = 1'b0;
    chk("post_rst_valid", valid, 0);
    chk("post_rst_rdy", rdy, 0);
    run_frame(7'b1100110, 30, 0, 1'b1, "after_rst");
    run_frame(7'h00, 30, 0, 1'b1, "zero");
    chk("zero_seed_state", seed_state, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/service_descrambler.md
Name: service_descrambler

Overview:
- Receive-side counterpart of the 802.11a PPDU scrambler (polynomial S(x) = x^7 + x^4 + 1).
- The transmitter's seed is not known in advance. The block recovers it from the first 7 SERVICE bits, which are zero before scrambling, then descrambles the rest of the frame bit-serially.
- Sits after the deinterleaver/Viterbi decoder and before the MAC-side bit sink. Uses the same run/valid/rdy bit-serial handshake as the transmit scrambler.

Parameters:
- SERVICE_LEN, 16, SERVICE field length in bits; must be >= 7.
- SEED_LEN, 7, LFSR length; fixed by the standard, exposed for the package only.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; arms the block for a new frame.
- run  in  1  input bit valid.
- x  in  1  scrambled input bit.
- last  in  1  qualifies the final bit of the frame when run=1.
- rdy  out  1  block can accept a bit this cycle.
- x_descrambled  out  1  descrambled bit.
- valid  out  1  x_descrambled valid.
- last_out  out  1  final output bit of the frame.
- seed_state  out  7  LFSR contents after the 7th SERVICE bit.
- seed_valid  out  1  seed_state valid; held until next start/reset.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, lfsr=0, bit counter=0; all outputs 0 except rdy=0.
  - Reset mid-frame aborts the frame with no further valid.
- FSM states: IDLE, SEED, RUN, FLUSH.
  - IDLE: rdy=0. start -> SEED with counter cleared, lfsr cleared, seed_valid cleared.
  - SEED: rdy=1. Each accepted bit (run&rdy):
    - lfsr <= {lfsr[5:0], x};
    - output 0 (the recovered SERVICE bit);
    - counter++.
    - On the 7th accepted bit -> RUN; seed_valid=1 on the following cycle.
  - RUN: rdy=1. Per accepted bit:
    - fb = lfsr[6]^lfsr[3];
    - x_descrambled = x^fb;
    - lfsr <= {lfsr[5:0], fb};
    - counter saturates at SERVICE_LEN.
  - An accepted bit with last=1 in either SEED or RUN -> FLUSH.
  - FLUSH: rdy=0; one cycle to drain the output register, then -> IDLE.
- Latency: outputs registered; valid asserted exactly 1 cycle after each accepted bit. last_out accompanies the output of the bit that carried last.
- Throughput: one bit per cycle; run may be gapped arbitrarily; lfsr advances only on accepted bits.
- Boundary cases:
  - last during SEED (frame shorter than 7 bits) → seed_valid stays 0, frame ends normally.
  - start while not IDLE → restarts in SEED and discards the partial frame; the in-flight output of the same cycle is still emitted.
  - run while rdy=0 → ignored.
  - Recovered state all-zero → descrambling continues unchanged (output = input). This is not flagged except under the optional feature.

Optional Feature:
- SERVICE_STRIP_EN:
  - When defined, valid is suppressed for the first SERVICE_LEN accepted bits; only PSDU/tail/pad bits are emitted.
  - If last occurs within SERVICE, last_out is still emitted with valid=1 and x_descrambled=0.
  - When undefined, every accepted bit, including all SERVICE bits, produces a valid output.

Decomposition:
- Shared package phy_scrambler_pkg:
  - SEED_LEN, SERVICE_LEN_DEFAULT;
  - tap positions TAP_A=6, TAP_B=3;
  - FSM state enum;
  - function lfsr_step(state) returning {next_state, fb}.
- Both the existing scrambler and this block use the package.
- One natural sub-module: scrambler_lfsr_core. It holds the 7-bit register with load-serial (SEED) and free-run (RUN) modes plus the enable. The FSM/counter/handshake stays in service_descrambler.

Test Plan:
- Standard all-ones seed: 7 scrambled SERVICE bits 0000111 followed by scrambled PSDU → x_descrambled 0000000 then the original PSDU; seed_state=7'b0000111 with seed_valid=1.
- Loopback with the existing scrambler, initialState=7'b1000011 and 7'b1011101, 1000 random bits → zero mismatches; valid count = bits in (fewer by 16 under SERVICE_STRIP_EN).
- Gapped run (run high 1 in 3 cycles) → identical output sequence to ungapped; valid exactly 1 cycle after each accepted bit.
- last on 4th bit → last_out with the 4th output; seed_valid stays 0; rdy returns high only after the next start.
- start asserted mid-RUN and reset pulsed low mid-RUN → new frame seeds correctly from its own SERVICE bits; after reset all outputs are 0 and rdy=0 until start.
- All-zero scrambled SERVICE bits → seed_state=0; subsequent outputs equal inputs.
